// File: rtl/src_ctrl_pkg.sv
// Shared definitions for the Mini-SRC control sequencer.
// Latency: n/a (constants, types and one pure helper function).
// Backpressure: n/a.
//
// Contents: opcode values, ALU function codes, the control-step state
// encoding, the opcode class set produced by op_class_decode, and the
// immediate-opcode to ALU-function mapping.
package src_ctrl_pkg;

  localparam int OP_W  = 5;
  localparam int ALU_W = 5;

  // Opcode field values (ir[31:27])
  localparam logic [OP_W-1:0] OP_LD   = 5'b00000;
  localparam logic [OP_W-1:0] OP_LDI  = 5'b00001;
  localparam logic [OP_W-1:0] OP_ST   = 5'b00010;
  localparam logic [OP_W-1:0] OP_ADD  = 5'b00011;
  localparam logic [OP_W-1:0] OP_SUB  = 5'b00100;
  localparam logic [OP_W-1:0] OP_AND  = 5'b00101;
  localparam logic [OP_W-1:0] OP_OR   = 5'b00110;
  localparam logic [OP_W-1:0] OP_ADDI = 5'b01100;
  localparam logic [OP_W-1:0] OP_ANDI = 5'b01101;
  localparam logic [OP_W-1:0] OP_ORI  = 5'b01110;
  localparam logic [OP_W-1:0] OP_NOP  = 5'b11010;
  localparam logic [OP_W-1:0] OP_HALT = 5'b11011;

  // ALU function codes; these deliberately equal the register-form
  // opcodes so the register ALU step can pass the opcode straight through.
  localparam logic [ALU_W-1:0] ALU_ADD = 5'b00011;
  localparam logic [ALU_W-1:0] ALU_SUB = 5'b00100;
  localparam logic [ALU_W-1:0] ALU_AND = 5'b00101;
  localparam logic [ALU_W-1:0] ALU_OR  = 5'b00110;

  // Control steps. T0..T2 are the shared fetch, T3..T7 the execute steps.
  typedef enum logic [3:0] {
    ST_IDLE,
    ST_T0,
    ST_T1,
    ST_T2,
    ST_T3,
    ST_T4,
    ST_T5,
    ST_T6,
    ST_T7,
    ST_HALT
  } state_t;

  // Instruction classes: every opcode in a class uses the same step sequence.
  typedef enum logic [2:0] {
    CL_ALU_R,
    CL_ALU_I,
    CL_LDI,
    CL_LD,
    CL_ST,
    CL_NOP,
    CL_HALT,
    CL_ILLEGAL
  } op_class_t;

  // ALU function for the immediate-form ALU instructions.
  function automatic logic [ALU_W-1:0] imm_alu_fn(input logic [OP_W-1:0] op);
    logic [ALU_W-1:0] fn;
    case (op)
      OP_ANDI: fn = ALU_AND;
      OP_ORI:  fn = ALU_OR;
      default: fn = ALU_ADD;
    endcase
    return fn;
  endfunction

endpackage

// File: rtl/op_class_decode.sv
// Opcode classifier: maps the 5-bit opcode to its instruction class.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows the input every cycle.
//
// Ports:
//   opcode  in   ir[31:27]
//   op_cls  out  instruction class (unknown opcodes map to CL_ILLEGAL)
module op_class_decode
  import src_ctrl_pkg::*;
(
  input  logic [OP_W-1:0] opcode,
  output op_class_t       op_cls
);

  always_comb begin
    op_cls = CL_ILLEGAL;
    case (opcode)
      OP_ADD, OP_SUB, OP_AND, OP_OR: op_cls = CL_ALU_R;
      OP_ADDI, OP_ANDI, OP_ORI:      op_cls = CL_ALU_I;
      OP_LDI:                        op_cls = CL_LDI;
      OP_LD:                         op_cls = CL_LD;
      OP_ST:                         op_cls = CL_ST;
      OP_NOP:                        op_cls = CL_NOP;
      OP_HALT:                       op_cls = CL_HALT;
      default:                       op_cls = CL_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/ctrl_sequencer.sv
// Moore control-step sequencer for the Mini-SRC datapath (fetch + ld/ldi/st/ALU/nop/halt).
// Latency: strobes are combinational from the current step; illegal_op is registered (cycle after T3).
// Backpressure: T1 (fetch read), T6 (ld read) and T7 (st write) hold until mem_ready=1.
//
// Ports:
//   clock, reset          rising-edge clock, synchronous active-low reset
//   ir, mem_ready         instruction register contents, memory completion
//   PCout PCin IncPC      PC bus drive / load / increment
//   MARin MDRin MDRout    MAR load, MDR load, MDR bus drive
//   Read Write            memory strobes
//   IRin Yin Zin Zlowout  IR/Y/Z loads, Zlow bus drive
//   Gra Grb Grc Rin Rout BAout Cout   register select/encode controls
//   alu_op                ALU function code
//   halted, illegal_op    stopped indicator, one-cycle unsupported-opcode pulse
module ctrl_sequencer
  import src_ctrl_pkg::*;
#(
  parameter int OPW  = 5,
  parameter int ALUW = 5
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [31:0]     ir,
  input  logic            mem_ready,
  output logic            PCout,
  output logic            PCin,
  output logic            IncPC,
  output logic            MARin,
  output logic            MDRin,
  output logic            MDRout,
  output logic            Read,
  output logic            Write,
  output logic            IRin,
  output logic            Yin,
  output logic            Zin,
  output logic            Zlowout,
  output logic            Gra,
  output logic            Grb,
  output logic            Grc,
  output logic            Rin,
  output logic            Rout,
  output logic            BAout,
  output logic            Cout,
  output logic [ALUW-1:0] alu_op,
  output logic            halted,
  output logic            illegal_op
);

  state_t          state;
  op_class_t       op_cls;
  logic [OPW-1:0]  opcode;
  // Set while T1 is being held for memory, so PCin fires only on T1 entry.
  logic            t1_wait;

  assign opcode = ir[31 -: OPW];

  // Operand/immediate fields are consumed by the datapath, not here.
  logic unused_ir_fields;
  assign unused_ir_fields = ^ir[31-OPW:0];

  op_class_decode u_decode (
    .opcode (opcode),
    .op_cls (op_cls)
  );

  // ---------------------------------------------------------------------
  // Step register, fetch-wait flag and registered illegal-opcode pulse
  // ---------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (!reset) begin
      state      <= ST_IDLE;
      t1_wait    <= 1'b0;
      illegal_op <= 1'b0;
    end else begin
      t1_wait    <= (state == ST_T1) && !mem_ready;
      illegal_op <= (state == ST_T3) && (op_cls == CL_ILLEGAL);

      case (state)
        ST_IDLE: state <= ST_T0;
        ST_T0:   state <= ST_T1;
        ST_T1:   if (mem_ready) state <= ST_T2;
        ST_T2:   state <= ST_T3;
        ST_T3: begin
          case (op_cls)
            CL_ALU_R, CL_ALU_I, CL_LDI, CL_LD, CL_ST: state <= ST_T4;
            CL_HALT: state <= ST_HALT;
            // nop and unsupported opcodes go straight back to fetch
            default: state <= ST_T0;
          endcase
        end
        ST_T4:   state <= ST_T5;
        ST_T5: begin
          if (op_cls == CL_LD || op_cls == CL_ST) state <= ST_T6;
          else                                    state <= ST_T0;
        end
        // Only ld waits in T6; st uses T6 to stage the store data.
        ST_T6: begin
          if (!(op_cls == CL_LD && !mem_ready)) state <= ST_T7;
        end
        // Only st waits in T7; ld's T7 is the register write-back.
        ST_T7: begin
          if (!(op_cls == CL_ST && !mem_ready)) state <= ST_T0;
        end
        ST_HALT: state <= ST_HALT;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Per-step control strobes (Moore: step + opcode class only)
  // ---------------------------------------------------------------------
  always_comb begin
    PCout   = 1'b0;
    PCin    = 1'b0;
    IncPC   = 1'b0;
    MARin   = 1'b0;
    MDRin   = 1'b0;
    MDRout  = 1'b0;
    Read    = 1'b0;
    Write   = 1'b0;
    IRin    = 1'b0;
    Yin     = 1'b0;
    Zin     = 1'b0;
    Zlowout = 1'b0;
    Gra     = 1'b0;
    Grb     = 1'b0;
    Grc     = 1'b0;
    Rin     = 1'b0;
    Rout    = 1'b0;
    BAout   = 1'b0;
    Cout    = 1'b0;
    alu_op  = '0;
    halted  = 1'b0;

    case (state)
      ST_T0: begin
        PCout  = 1'b1;
        MARin  = 1'b1;
        IncPC  = 1'b1;
        Zin    = 1'b1;
        alu_op = ALU_ADD;
      end
      ST_T1: begin
        Zlowout = 1'b1;
        PCin    = !t1_wait;
        Read    = 1'b1;
        MDRin   = 1'b1;
      end
      ST_T2: begin
        MDRout = 1'b1;
        IRin   = 1'b1;
      end
      ST_T3: begin
        case (op_cls)
          CL_ALU_R, CL_ALU_I: begin
            Grb  = 1'b1;
            Rout = 1'b1;
            Yin  = 1'b1;
          end
          // ldi/ld/st use base-address form: R0 as base reads as zero.
          CL_LDI, CL_LD, CL_ST: begin
            Grb   = 1'b1;
            BAout = 1'b1;
            Yin   = 1'b1;
          end
          default: ;
        endcase
      end
      ST_T4: begin
        case (op_cls)
          CL_ALU_R: begin
            Grc    = 1'b1;
            Rout   = 1'b1;
            Zin    = 1'b1;
            alu_op = opcode;
          end
          CL_ALU_I: begin
            Cout   = 1'b1;
            Zin    = 1'b1;
            alu_op = imm_alu_fn(opcode);
          end
          CL_LDI, CL_LD, CL_ST: begin
            Cout   = 1'b1;
            Zin    = 1'b1;
            alu_op = ALU_ADD;
          end
          default: ;
        endcase
      end
      ST_T5: begin
        case (op_cls)
          CL_ALU_R, CL_ALU_I, CL_LDI: begin
            Zlowout = 1'b1;
            Gra     = 1'b1;
            Rin     = 1'b1;
          end
          CL_LD, CL_ST: begin
            Zlowout = 1'b1;
            MARin   = 1'b1;
          end
          default: ;
        endcase
      end
      ST_T6: begin
        case (op_cls)
          CL_LD: begin
            Read  = 1'b1;
            MDRin = 1'b1;
          end
          CL_ST: begin
            Gra   = 1'b1;
            Rout  = 1'b1;
            MDRin = 1'b1;
          end
          default: ;
        endcase
      end
      ST_T7: begin
        case (op_cls)
          CL_LD: begin
            MDRout = 1'b1;
            Gra    = 1'b1;
            Rin    = 1'b1;
          end
          CL_ST: Write = 1'b1;
          default: ;
        endcase
      end
      ST_HALT: halted = 1'b1;
      default: ;
    endcase
  end

endmodule
